// File: rtl/mem_access_controller.sv
// CPU/loader memory sequencer: big-endian byte lanes, sign/zero extension, RAM arbitration.
// Alignment trapping is compiled in when MEMCTL_ALIGN_CHECK_EN is defined.
module mem_access_controller #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic              SU,
    input  logic [31:0]       MAR,
    input  logic [31:0]       MDR_Out,
    output logic              MOC,
    output logic [31:0]       Mem_Data,
    output logic              Align_Trap,
    input  logic              Ld_Req,
    input  logic [31:0]       Ld_Addr,
    input  logic [31:0]       Ld_Data,
    output logic              Ld_Ack,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic              Ram_WE,
    output logic [3:0]        Ram_BE,
    output logic [31:0]       Ram_WData,
    input  logic [31:0]       Ram_RData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RELEASE
`ifdef MEMCTL_ALIGN_CHECK_EN
        , S_TRAP
`endif
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              su_q;
    logic              ld_q;
    logic [1:0]        cnt;
    logic [31:0]       mem_data_q;

    logic              rd_last;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       ext;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic              unused;

    assign unused  = ^{MAR[31:ADDR_W+2], Ld_Addr[31:ADDR_W+2]};
    assign rd_last = (cnt == 2'(RD_LAT - 1));

`ifdef MEMCTL_ALIGN_CHECK_EN
    logic illegal;
    assign illegal = (SIZE == 2'b11)
                   || (SIZE == 2'b01 && MAR[0])
                   || (SIZE == 2'b10 && MAR[1:0] != 2'b00);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (Ld_Req) begin
                    state_nx = S_ISSUE;
                end else if (MOV) begin
`ifdef MEMCTL_ALIGN_CHECK_EN
                    state_nx = illegal ? S_TRAP : S_ISSUE;
`else
                    state_nx = S_ISSUE;
`endif
                end
            end
            S_ISSUE:   state_nx = rw_q ? S_WAIT : S_DONE;
            S_WAIT:    if (rd_last) state_nx = S_DONE;
            S_DONE:    state_nx = S_RELEASE;
`ifdef MEMCTL_ALIGN_CHECK_EN
            S_TRAP:    state_nx = S_RELEASE;
`endif
            // Hold here until the owner drops its level request.
            S_RELEASE: if (!(ld_q ? Ld_Req : MOV)) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'b00: begin
                be = 4'b1000 >> addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b0011 : 4'b1100;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   rbyte = Ram_RData[31:24];
            2'b01:   rbyte = Ram_RData[23:16];
            2'b10:   rbyte = Ram_RData[15:8];
            default: rbyte = Ram_RData[7:0];
        endcase
        rhalf = addr_q[1] ? Ram_RData[15:0] : Ram_RData[31:16];
        unique case (size_q)
            2'b00:   ext = su_q ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            2'b01:   ext = su_q ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            default: ext = Ram_RData;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            su_q       <= 1'b0;
            ld_q       <= 1'b0;
            cnt        <= 2'd0;
            mem_data_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_WAIT) ? cnt + 2'd1 : 2'd0;
            if (state == S_IDLE) begin
                if (Ld_Req) begin
                    addr_q  <= Ld_Addr[ADDR_W+1:0];
                    wdata_q <= Ld_Data;
                    rw_q    <= 1'b0;
                    size_q  <= 2'b10;
                    su_q    <= 1'b0;
                    ld_q    <= 1'b1;
                end else if (MOV) begin
                    addr_q  <= MAR[ADDR_W+1:0];
                    wdata_q <= MDR_Out;
                    rw_q    <= RW;
                    size_q  <= SIZE;
                    su_q    <= SU;
                    ld_q    <= 1'b0;
                end
            end
            if (state == S_WAIT && rd_last) mem_data_q <= ext;
        end
    end

    // Strobes are gated by Reset so nothing leaks out of a reset cycle.
    always_comb begin
        MOC        = 1'b0;
        Ld_Ack     = 1'b0;
        Align_Trap = 1'b0;
        Ram_WE     = 1'b0;
        Ram_Addr   = '0;
        Ram_BE     = 4'b0000;
        Ram_WData  = '0;
        if (!Reset) begin
            if (state == S_ISSUE) begin
                Ram_Addr  = addr_q[ADDR_W+1:2];
                Ram_BE    = be;
                Ram_WData = wd;
                Ram_WE    = !rw_q;
            end
            if (state == S_DONE) begin
                MOC    = !ld_q;
                Ld_Ack = ld_q;
            end
`ifdef MEMCTL_ALIGN_CHECK_EN
            if (state == S_TRAP) Align_Trap = 1'b1;
`endif
        end
    end

    assign Mem_Data = mem_data_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Scoreboard bench for mem_access_controller against a byte-array reference memory.
module tb_mem_access_controller;

    localparam int ADDR_W = 9;
    localparam int RD_LAT = 3;
    localparam int NBYTES = 4 << ADDR_W;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              MOV = 1'b0;
    logic              RW = 1'b0;
    logic [1:0]        SIZE = 2'b00;
    logic              SU = 1'b0;
    logic [31:0]       MAR = '0;
    logic [31:0]       MDR_Out = '0;
    logic              Ld_Req = 1'b0;
    logic [31:0]       Ld_Addr = '0;
    logic [31:0]       Ld_Data = '0;
    logic              MOC;
    logic [31:0]       Mem_Data;
    logic              Align_Trap;
    logic              Ld_Ack;
    logic [ADDR_W-1:0] Ram_Addr;
    logic              Ram_WE;
    logic [3:0]        Ram_BE;
    logic [31:0]       Ram_WData;
    logic [31:0]       Ram_RData;

    always #5 Clock = ~Clock;

    mem_access_controller #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .Clock(Clock), .Reset(Reset), .MOV(MOV), .RW(RW), .SIZE(SIZE),
        .SU(SU), .MAR(MAR), .MDR_Out(MDR_Out), .MOC(MOC),
        .Mem_Data(Mem_Data), .Align_Trap(Align_Trap), .Ld_Req(Ld_Req),
        .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Ld_Ack(Ld_Ack),
        .Ram_Addr(Ram_Addr), .Ram_WE(Ram_WE), .Ram_BE(Ram_BE),
        .Ram_WData(Ram_WData), .Ram_RData(Ram_RData)
    );

    // RAM macro: synchronous, RD_LAT-stage read pipeline.
    logic [31:0] ram  [0:(1<<ADDR_W)-1];
    logic [31:0] pipe [0:RD_LAT-1];
    always @(posedge Clock) begin
        if (Ram_WE)
            for (int b = 0; b < 4; b++)
                if (Ram_BE[b]) ram[Ram_Addr][8*b +: 8] <= Ram_WData[8*b +: 8];
        pipe[0] <= ram[Ram_Addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign Ram_RData = pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wd;
    } wr_t;

    exp_t q[$];
    wr_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;

    logic [7:0] mb [0:NBYTES-1];

    function automatic logic [31:0] ref_read(input int bi, input logic [1:0] sz,
                                             input logic su);
        int h, w;
        logic [7:0] bv;
        logic [15:0] hv;
        case (sz)
            2'b00: begin
                bv = mb[bi];
                return su ? {{24{bv[7]}}, bv} : {24'h0, bv};
            end
            2'b01: begin
                h  = bi & ~1;
                hv = {mb[h], mb[h+1]};
                return su ? {{16{hv[15]}}, hv} : {16'h0, hv};
            end
            default: begin
                w = bi & ~3;
                return {mb[w], mb[w+1], mb[w+2], mb[w+3]};
            end
        endcase
    endfunction

    task automatic ref_write(input int bi, input logic [1:0] sz,
                             input logic [31:0] d, output wr_t w);
        int h;
        w.addr = ADDR_W'(bi >> 2);
        case (sz)
            2'b00: begin
                mb[bi] = d[7:0];
                w.be   = 4'(1 << (3 - (bi % 4)));
                w.wd   = {4{d[7:0]}};
            end
            2'b01: begin
                h       = bi & ~1;
                mb[h]   = d[15:8];
                mb[h+1] = d[7:0];
                w.be    = ((bi & 2) != 0) ? 4'b0011 : 4'b1100;
                w.wd    = {2{d[15:0]}};
            end
            default: begin
                h       = bi & ~3;
                mb[h]   = d[31:24];
                mb[h+1] = d[23:16];
                mb[h+2] = d[15:8];
                mb[h+3] = d[7:0];
                w.be    = 4'b1111;
                w.wd    = d;
            end
        endcase
    endtask

    task automatic wait_resp(input bit ld);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clock);
            seen = ld ? Ld_Ack : (MOC | Align_Trap);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL resp_timeout: no response within 40 cycles (ld=%0d)", ld);
        end
    endtask

    task automatic cpu_op(input logic rw, input logic [1:0] sz, input logic su,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        wr_t  w;
        int   bi;
        logic trap;
        bi   = int'(a[ADDR_W+1:0]);
        trap = 1'b0;
`ifdef MEMCTL_ALIGN_CHECK_EN
        trap = (sz == 2'b11) || (sz == 2'b01 && a[0])
             || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
        @(posedge Clock); #1;
        MOV = 1'b1; RW = rw; SIZE = sz; SU = su; MAR = a; MDR_Out = d;
        e.data = '0;
        e.chk  = 1'b0;
        if (trap) begin
            e.kind = 3'b100;
            e.cyc  = cyc + 1;
        end else if (rw) begin
            e.kind = 3'b001;
            e.cyc  = cyc + 2 + RD_LAT;
            e.chk  = 1'b1;
            e.data = ref_read(bi, sz, su);
        end else begin
            e.kind = 3'b001;
            e.cyc  = cyc + 2;
            ref_write(bi, sz, d, w);
            wq.push_back(w);
        end
        q.push_back(e);
        wait_resp(1'b0);
        @(posedge Clock); #1;
        MOV = 1'b0;
        @(posedge Clock);
    endtask

    task automatic ld_op(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        wr_t  w;
        @(posedge Clock); #1;
        Ld_Req = 1'b1; Ld_Addr = a; Ld_Data = d;
        ref_write(int'(a[ADDR_W+1:0]) & ~3, 2'b10, d, w);
        wq.push_back(w);
        e.kind = 3'b010; e.data = '0; e.chk = 1'b0; e.cyc = cyc + 2;
        q.push_back(e);
        wait_resp(1'b1);
        @(posedge Clock); #1;
        Ld_Req = 1'b0;
        @(posedge Clock);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({MOC, Align_Trap, Ld_Ack, Ram_WE} !== 4'b0 || Ram_BE !== 4'b0
            || Ram_Addr !== '0 || Ram_WData !== '0 || Mem_Data !== '0) begin
            errors++;
            $display("FAIL %s: strobes %b be %b addr %h wdata %h mem_data %h, want all 0",
                     name, {MOC, Align_Trap, Ld_Ack, Ram_WE}, Ram_BE, Ram_Addr,
                     Ram_WData, Mem_Data);
        end
    endtask

    always @(negedge Clock) begin : monitor
        exp_t e;
        wr_t  w;
        if (Reset) begin
            checks++;
            if ({MOC, Ld_Ack, Align_Trap, Ram_WE} !== 4'b0) begin
                errors++;
                $display("FAIL reset_strobes: got %b, want 0000",
                         {MOC, Ld_Ack, Align_Trap, Ram_WE});
            end
        end else begin
            if (Ram_WE) begin
                wcount++;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h be %b data %h",
                             Ram_Addr, Ram_BE, Ram_WData);
                end else begin
                    w = wq.pop_front();
                    if (Ram_Addr !== w.addr || Ram_BE !== w.be || Ram_WData !== w.wd) begin
                        errors++;
                        $display("FAIL write_lanes: got addr %h be %b data %h, want addr %h be %b data %h",
                                 Ram_Addr, Ram_BE, Ram_WData, w.addr, w.be, w.wd);
                    end
                end
            end
            if (MOC | Ld_Ack | Align_Trap) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: trap/ack/moc %b at cycle %0d",
                             {Align_Trap, Ld_Ack, MOC}, cyc);
                end else begin
                    e = q.pop_front();
                    if ({Align_Trap, Ld_Ack, MOC} !== e.kind || cyc != e.cyc
                        || (e.chk && Mem_Data !== e.data)) begin
                        errors++;
                        $display("FAIL response: got kind %b cycle %0d data %h, want kind %b cycle %0d data %h",
                                 {Align_Trap, Ld_Ack, MOC}, cyc, Mem_Data,
                                 e.kind, e.cyc, e.chk ? e.data : Mem_Data);
                    end
                end
            end
        end
    end

    initial begin
        exp_t        e;
        wr_t         w;
        int          k;
        int          wbase;
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check_zero("reset_state");

        for (int i = 0; i < 32; i++) ld_op(32'(i * 4), $urandom);

        cpu_op(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        cpu_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        cpu_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        cpu_op(1'b1, 2'b00, 1'b1, 32'h11, 32'h0);
        cpu_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0);
        cpu_op(1'b1, 2'b01, 1'b1, 32'h12, 32'h0);
        cpu_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h123456AB);
        cpu_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        cpu_op(1'b1, 2'b10, 1'b0, 32'h06, 32'h0);
        cpu_op(1'b1, 2'b01, 1'b1, 32'h13, 32'h0);
        cpu_op(1'b1, 2'b11, 1'b0, 32'h08, 32'h0);
        cpu_op(1'b1, 2'b10, 1'b0, 32'hF000_0810, 32'h0);

        // Loader and CPU request together: loader first, CPU write exactly once.
        wbase = wcount;
        @(posedge Clock); #1;
        d = $urandom;
        Ld_Req = 1'b1; Ld_Addr = 32'h40; Ld_Data = d;
        MOV = 1'b1; RW = 1'b0; SIZE = 2'b10; MAR = 32'h44; MDR_Out = ~d;
        k = cyc + 1;
        ref_write(32'h40, 2'b10, d, w);
        wq.push_back(w);
        e.kind = 3'b010; e.data = '0; e.chk = 1'b0; e.cyc = k + 1;
        q.push_back(e);
        ref_write(32'h44, 2'b10, ~d, w);
        wq.push_back(w);
        e.kind = 3'b001; e.cyc = k + 5;
        q.push_back(e);
        wait_resp(1'b1);
        @(posedge Clock); #1;
        Ld_Req = 1'b0;
        wait_resp(1'b0);
        repeat (5) @(posedge Clock);
        #1 MOV = 1'b0;
        @(posedge Clock);
        checks++;
        if (wcount - wbase != 2) begin
            errors++;
            $display("FAIL arb_access_count: got %0d writes, want 2", wcount - wbase);
        end
        cpu_op(1'b1, 2'b10, 1'b0, 32'h44, 32'h0);

        // Reset in the middle of a read wait: no completion may follow.
        @(posedge Clock); #1;
        MOV = 1'b1; RW = 1'b1; SIZE = 2'b10; MAR = 32'h10;
        @(posedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b1; MOV = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_zero("after_wait_reset");
        cpu_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom & ~(32'(NBYTES) - 32'd1)) | 32'($urandom_range(0, 127));
            d = $urandom;
            if ($urandom_range(0, 7) == 0)
                ld_op(a, d);
            else
                cpu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), a, d);
        end

        repeat (10) @(posedge Clock);
        checks++;
        if (q.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses and %0d writes outstanding, want 0",
                     q.size(), wq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
